// File: rtl/alu_result_checker.sv
// alu_result_checker: recomputes the golden result and flags for one ALU beat
// per clock and compares them with what the ALU produced. It keeps saturating
// pass/fail counts, captures the first failing beat and can halt on a mismatch.
// Beats land in a stage-1 register; the compare and count happen one edge later.
module alu_result_checker #(
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      a_i,
  input  logic [31:0]      b_i,
  input  logic [3:0]       aluc_i,
  input  logic [31:0]      r_i,
  input  logic             zero_i,
  input  logic             carry_i,
  input  logic             negative_i,
  input  logic             overflow_i,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic             fail_o,
  output logic [3:0]       ff_aluc_o,
  output logic [31:0]      ff_a_o,
  output logic [31:0]      ff_b_o,
  output logic [31:0]      ff_r_o,
  output logic [31:0]      ff_exp_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Golden ALU result; the shift amount comes from a[4:0] and b is shifted.
  function automatic logic [31:0] golden_r(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] res;
    res = 32'h0000_0000;
    case (op)
      4'b0000, 4'b0010: res = a + b;
      4'b0001, 4'b0011: res = a - b;
      4'b0100:          res = a & b;
      4'b0101:          res = a | b;
      4'b0110:          res = a ^ b;
      4'b0111:          res = ~(a | b);
      4'b1000, 4'b1001: res = {b[15:0], 16'h0000};
      4'b1011:          res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1010:          res = (a < b) ? 32'd1 : 32'd0;
      4'b1100:          res = $unsigned($signed(b) >>> a[4:0]);
      4'b1101:          res = b >> a[4:0];
      4'b1110, 4'b1111: res = b << a[4:0];
      default:          res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Compares observed result and the flags that matter for this opcode.
  function automatic logic beat_mismatch(input logic [3:0]  op,
                                         input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] r,
                                         input logic        z,
                                         input logic        c,
                                         input logic        n,
                                         input logic        v,
                                         input logic [31:0] exp);
    logic m;
    logic neg_checked;
    neg_checked = (op != 4'b1011) && (op != 4'b1010);
    m = (r != exp) || (z != (exp == 32'h0000_0000));
    m = m || (neg_checked && (n != exp[31]));
    case (op)
      // For ADDU exp = a+b mod 2^32, so the carry out is set exactly when it wrapped below a.
      4'b0000:          m = m || (c != (exp < a));
      4'b0001, 4'b1010: m = m || (c != (a < b));
      default:          m = m;
    endcase
    case (op)
      4'b0010: m = m || (v != ((a[31] == b[31]) && (exp[31] != a[31])));
      4'b0011: m = m || (v != ((a[31] != b[31]) && (exp[31] != a[31])));
      default: m = m;
    endcase
    return m;
  endfunction

  state_t      state_q, state_d;
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_a_q, s1_b_q, s1_r_q;
  logic [3:0]  s1_aluc_q;
  logic        s1_zero_q, s1_carry_q, s1_neg_q, s1_ovf_q;
  logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q;
  logic        fail_q;
  logic [3:0]  ff_aluc_q;
  logic [31:0] ff_a_q, ff_b_q, ff_r_q, ff_exp_q;
  logic [31:0] golden_exp;
  logic        beat_bad;
  logic        accept;
  logic        halt_entry;

  assign golden_exp = golden_r(s1_aluc_q, s1_a_q, s1_b_q);
  assign beat_bad   = beat_mismatch(s1_aluc_q, s1_a_q, s1_b_q, s1_r_q, s1_zero_q,
                                    s1_carry_q, s1_neg_q, s1_ovf_q, golden_exp);
  assign accept     = in_valid_i & in_ready_o;
  assign halt_entry = (state_q == ST_RUN) && (state_d == ST_HALT);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start always (re)enters RUN; a mismatch may halt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
        else         state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (start_i)                                           state_d = ST_RUN;
        else if (s1_valid_q && beat_bad && (STOP_ON_FAIL != 1'b0)) state_d = ST_HALT;
        else                                                   state_d = ST_RUN;
      end
      ST_HALT: begin
        if (start_i) state_d = ST_RUN;
        else         state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: beats are accepted only while running.
  always_comb begin
    in_ready_o = (state_q == ST_RUN);
    state_o    = state_q;
  end

  // Stage-1 valid: start flushes it, and a beat arriving as we halt is dropped.
  always_comb begin
    if (start_i) s1_valid_d = 1'b0;
    else         s1_valid_d = accept & ~halt_entry;
  end

  // Stage-1 beat capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= 32'h0000_0000;
      s1_b_q     <= 32'h0000_0000;
      s1_r_q     <= 32'h0000_0000;
      s1_aluc_q  <= 4'h0;
      s1_zero_q  <= 1'b0;
      s1_carry_q <= 1'b0;
      s1_neg_q   <= 1'b0;
      s1_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_a_q     <= a_i;
        s1_b_q     <= b_i;
        s1_r_q     <= r_i;
        s1_aluc_q  <= aluc_i;
        s1_zero_q  <= zero_i;
        s1_carry_q <= carry_i;
        s1_neg_q   <= negative_i;
        s1_ovf_q   <= overflow_i;
      end
    end
  end

  // Counters, sticky fail and first-fail capture; start clears and wins over an update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      fail_q     <= 1'b0;
      ff_aluc_q  <= 4'h0;
      ff_a_q     <= 32'h0000_0000;
      ff_b_q     <= 32'h0000_0000;
      ff_r_q     <= 32'h0000_0000;
      ff_exp_q   <= 32'h0000_0000;
    end else if (start_i) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      fail_q     <= 1'b0;
      ff_aluc_q  <= 4'h0;
      ff_a_q     <= 32'h0000_0000;
      ff_b_q     <= 32'h0000_0000;
      ff_r_q     <= 32'h0000_0000;
      ff_exp_q   <= 32'h0000_0000;
    end else if (s1_valid_q) begin
      if (beat_bad) begin
        if (fail_cnt_q != CNT_MAX) fail_cnt_q <= fail_cnt_q + CNT_ONE;
        fail_q <= 1'b1;
        if (!fail_q) begin
          ff_aluc_q <= s1_aluc_q;
          ff_a_q    <= s1_a_q;
          ff_b_q    <= s1_b_q;
          ff_r_q    <= s1_r_q;
          ff_exp_q  <= golden_exp;
        end
      end else begin
        if (pass_cnt_q != CNT_MAX) pass_cnt_q <= pass_cnt_q + CNT_ONE;
      end
    end
  end

  assign pass_cnt_o = pass_cnt_q;
  assign fail_cnt_o = fail_cnt_q;
  assign fail_o     = fail_q;
  assign ff_aluc_o  = ff_aluc_q;
  assign ff_a_o     = ff_a_q;
  assign ff_b_o     = ff_b_q;
  assign ff_r_o     = ff_r_q;
  assign ff_exp_o   = ff_exp_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: two instances (halting 16-bit counters and a
// non-halting 4-bit-counter variant) fed from shared operand buses. The driver
// pushes expected counter state per issued beat; per-instance monitors pop and
// compare two edges after each observed handshake.
module tb_alu_result_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b, valid_a, valid_b;
  logic        ready_a, ready_b;
  logic [31:0] a_s, b_s, r_s;
  logic [3:0]  aluc_s;
  logic        z_s, c_s, n_s, v_s;
  logic [15:0] pass_a, fcnt_a;
  logic [3:0]  pass_b, fcnt_b;
  logic        fail_a, fail_b;
  logic [3:0]  ffaluc_a, ffaluc_b;
  logic [31:0] ffa_a, ffb_a, ffr_a, ffexp_a, ffa_b, ffb_b, ffr_b, ffexp_b;
  logic [1:0]  state_a, state_b;

  typedef struct {
    logic [15:0] pass;
    logic [15:0] fcnt;
    logic        fl;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_a  = 0;
  int   pass_m[2];
  int   fcnt_m[2];
  bit   fl_m[2];
  int   max_m[2];
  logic pa1, pa2, pb1, pb2;

  always #5 clk = ~clk;

  alu_result_checker #(.CNT_W(16), .STOP_ON_FAIL(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .in_valid_i(valid_a),
    .in_ready_o(ready_a), .a_i(a_s), .b_i(b_s), .aluc_i(aluc_s), .r_i(r_s),
    .zero_i(z_s), .carry_i(c_s), .negative_i(n_s), .overflow_i(v_s),
    .pass_cnt_o(pass_a), .fail_cnt_o(fcnt_a), .fail_o(fail_a),
    .ff_aluc_o(ffaluc_a), .ff_a_o(ffa_a), .ff_b_o(ffb_a), .ff_r_o(ffr_a),
    .ff_exp_o(ffexp_a), .state_o(state_a));

  alu_result_checker #(.CNT_W(4), .STOP_ON_FAIL(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .in_valid_i(valid_b),
    .in_ready_o(ready_b), .a_i(a_s), .b_i(b_s), .aluc_i(aluc_s), .r_i(r_s),
    .zero_i(z_s), .carry_i(c_s), .negative_i(n_s), .overflow_i(v_s),
    .pass_cnt_o(pass_b), .fail_cnt_o(fcnt_b), .fail_o(fail_b),
    .ff_aluc_o(ffaluc_b), .ff_a_o(ffa_b), .ff_b_o(ffb_b), .ff_r_o(ffr_b),
    .ff_exp_o(ffexp_b), .state_o(state_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 0) start_a = 1'b1;
    else          start_b = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    pass_m[sel] = 0;
    fcnt_m[sel] = 0;
    fl_m[sel]   = 1'b0;
  endtask

  // Issue one beat; good = hand-judged ALU-correct, counted = beat should be scored.
  task automatic send(input int sel, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] r, input logic z,
                      input logic c, input logic n, input logic v,
                      input bit good, input bit counted);
    exp_t e;
    aluc_s = op; a_s = a; b_s = b; r_s = r;
    z_s = z; c_s = c; n_s = n; v_s = v;
    if (sel == 0) valid_a = 1'b1;
    else          valid_b = 1'b1;
    if (counted) begin
      if (good) begin
        if (pass_m[sel] < max_m[sel]) pass_m[sel]++;
      end else begin
        if (fcnt_m[sel] < max_m[sel]) fcnt_m[sel]++;
        fl_m[sel] = 1'b1;
      end
    end
    e.pass = 16'(pass_m[sel]);
    e.fcnt = 16'(fcnt_m[sel]);
    e.fl   = fl_m[sel];
    if (sel == 0) q_a.push_back(e);
    else          q_b.push_back(e);
    step();
  endtask

  task automatic idle();
    valid_a = 1'b0;
    valid_b = 1'b0;
    repeat (3) step();
  endtask

  // Monitor A: a handshake seen before edge N is scored at edge N+1.
  always @(negedge clk) begin
    if (rst) begin
      pa1 <= 1'b0;
      pa2 <= 1'b0;
    end else begin
      if (pa2) begin
        if (q_a.size() == 0) begin
          chk("a.unexpected_output", 32'd1, 32'd0);
        end else begin
          chk("a.pass_cnt", {16'h0, pass_a}, {16'h0, q_a[0].pass});
          chk("a.fail_cnt", {16'h0, fcnt_a}, {16'h0, q_a[0].fcnt});
          chk("a.fail", {31'h0, fail_a}, {31'h0, q_a[0].fl});
          void'(q_a.pop_front());
        end
      end
      pa2 <= pa1;
      pa1 <= valid_a & ready_a;
      if (valid_a & ready_a) acc_a <= acc_a + 1;
    end
  end

  // Monitor B: same scheme for the non-halting 4-bit instance.
  always @(negedge clk) begin
    if (rst) begin
      pb1 <= 1'b0;
      pb2 <= 1'b0;
    end else begin
      if (pb2) begin
        if (q_b.size() == 0) begin
          chk("b.unexpected_output", 32'd1, 32'd0);
        end else begin
          chk("b.pass_cnt", {28'h0, pass_b}, {16'h0, q_b[0].pass});
          chk("b.fail_cnt", {28'h0, fcnt_b}, {16'h0, q_b[0].fcnt});
          chk("b.fail", {31'h0, fail_b}, {31'h0, q_b[0].fl});
          void'(q_b.pop_front());
        end
      end
      pb2 <= pb1;
      pb1 <= valid_b & ready_b;
    end
  end

  logic [3:0]  t_op [6];
  logic [31:0] t_a  [6];
  logic [31:0] t_b  [6];
  logic [31:0] t_r  [6];
  logic [3:0]  t_fl [6];  // {z, c, n, v}

  initial begin
    int acc0;
    t_op[0] = 4'b0100; t_a[0] = 32'h5555_5555; t_b[0] = 32'hAAAA_AAAA; t_r[0] = 32'h0000_0000; t_fl[0] = 4'b1000;
    t_op[1] = 4'b0101; t_a[1] = 32'h5555_5555; t_b[1] = 32'hAAAA_AAAA; t_r[1] = 32'hFFFF_FFFF; t_fl[1] = 4'b0010;
    t_op[2] = 4'b0110; t_a[2] = 32'h5555_5555; t_b[2] = 32'hAAAA_AAAA; t_r[2] = 32'hFFFF_FFFF; t_fl[2] = 4'b0010;
    t_op[3] = 4'b0111; t_a[3] = 32'h5555_5555; t_b[3] = 32'hAAAA_AAAA; t_r[3] = 32'h0000_0000; t_fl[3] = 4'b1000;
    t_op[4] = 4'b1011; t_a[4] = 32'hFFFF_FFFF; t_b[4] = 32'h8000_0000; t_r[4] = 32'h0000_0000; t_fl[4] = 4'b1000;
    t_op[5] = 4'b1010; t_a[5] = 32'h8000_0000; t_b[5] = 32'hFFFF_FFFF; t_r[5] = 32'h0000_0001; t_fl[5] = 4'b0100;
    max_m[0] = 65535; max_m[1] = 15;
    pass_m[0] = 0; pass_m[1] = 0; fcnt_m[0] = 0; fcnt_m[1] = 0; fl_m[0] = 1'b0; fl_m[1] = 1'b0;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    a_s = 32'h0; b_s = 32'h0; r_s = 32'h0; aluc_s = 4'h0;
    z_s = 1'b0; c_s = 1'b0; n_s = 1'b0; v_s = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state.
    chk("rst.state_a", {30'h0, state_a}, 32'h0);
    chk("rst.ready_a", {31'h0, ready_a}, 32'h0);
    chk("rst.pass_a", {16'h0, pass_a}, 32'h0);
    chk("rst.fcnt_a", {16'h0, fcnt_a}, 32'h0);
    chk("rst.fail_a", {31'h0, fail_a}, 32'h0);
    chk("rst.ffexp_a", ffexp_a, 32'h0);
    chk("rst.state_b", {30'h0, state_b}, 32'h0);

    // 1: ADDU 7FFFFFFF+1 passes.
    pulse_start(0);
    chk("t1.state_run", {30'h0, state_a}, 32'h1);
    send(0, 4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle();
    chk("t1.pass_a", {16'h0, pass_a}, 32'h1);
    chk("t1.fail_a", {31'h0, fail_a}, 32'h0);

    // 2: ADD with missing overflow fails and halts; the next beat is dropped.
    send(0, 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    send(0, 4'b0000, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    idle();
    chk("t2.state_halt", {30'h0, state_a}, 32'h2);
    chk("t2.ready_a", {31'h0, ready_a}, 32'h0);
    chk("t2.pass_a", {16'h0, pass_a}, 32'h1);
    chk("t2.fcnt_a", {16'h0, fcnt_a}, 32'h1);
    chk("t2.ff_aluc", {28'h0, ffaluc_a}, 32'h2);
    chk("t2.ff_exp", ffexp_a, 32'h8000_0000);
    chk("t2.ff_a", ffa_a, 32'h7FFF_FFFF);
    chk("t2.ff_r", ffr_a, 32'h8000_0000);

    // 3: start from HALT, 16 back-to-back correct logic/compare beats.
    pulse_start(0);
    chk("t3.state_run", {30'h0, state_a}, 32'h1);
    chk("t3.cleared_fcnt", {16'h0, fcnt_a}, 32'h0);
    chk("t3.cleared_ff", {28'h0, ffaluc_a}, 32'h0);
    acc0 = acc_a;
    for (int i = 0; i < 16; i++) begin
      send(0, t_op[i % 6], t_a[i % 6], t_b[i % 6], t_r[i % 6],
           t_fl[i % 6][3], t_fl[i % 6][2], t_fl[i % 6][1], t_fl[i % 6][0], 1'b1, 1'b1);
    end
    idle();
    chk("t3.accepts", 32'(acc_a - acc0), 32'd16);
    chk("t3.pass_a", {16'h0, pass_a}, 32'd16);

    // 4: shifts and LUI.
    send(0, 4'b1100, 32'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    send(0, 4'b1101, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(0, 4'b1000, 32'h0, 32'h0000_1234, 32'h1234_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    chk("t4.pass_a", {16'h0, pass_a}, 32'd19);
    chk("t4.fcnt_a", {16'h0, fcnt_a}, 32'd0);

    // 5: two failures on the non-halting instance; capture keeps the first.
    pulse_start(1);
    send(1, 4'b0001, 32'h5, 32'h3, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(1, 4'b1110, 32'h4, 32'h1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("t5.fcnt_b", {28'h0, fcnt_b}, 32'd2);
    chk("t5.ff_aluc", {28'h0, ffaluc_b}, 32'h1);
    chk("t5.ff_a", ffa_b, 32'h5);
    chk("t5.ff_b", ffb_b, 32'h3);
    chk("t5.ff_r", ffr_b, 32'h3);
    chk("t5.ff_exp", ffexp_b, 32'h2);
    chk("t5.state_run", {30'h0, state_b}, 32'h1);

    // 6: start clears, 20 passes saturate a 4-bit counter, reset mid-run.
    pulse_start(1);
    chk("t6.clr_fcnt", {28'h0, fcnt_b}, 32'h0);
    chk("t6.clr_fail", {31'h0, fail_b}, 32'h0);
    chk("t6.clr_ffexp", ffexp_b, 32'h0);
    for (int i = 1; i <= 20; i++) begin
      send(1, 4'b0000, 32'(i), 32'h1, 32'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    idle();
    chk("t6.pass_sat", {28'h0, pass_b}, 32'hF);
    rst = 1'b1;
    step();
    chk("t6.rst_state_b", {30'h0, state_b}, 32'h0);
    chk("t6.rst_pass_b", {28'h0, pass_b}, 32'h0);
    chk("t6.rst_ready_b", {31'h0, ready_b}, 32'h0);
    chk("t6.rst_pass_a", {16'h0, pass_a}, 32'h0);
    rst = 1'b0;
    step();
    chk("end.q_a_empty", 32'(q_a.size()), 32'd0);
    chk("end.q_b_empty", 32'(q_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
